countdown: RTL and testbench
============================

# countdown

Loadable down-counting timer with an optional divide-by-PRESCALE tick, built as the decrementing counterpart of the team's prescaled up-counter. Software or a controller loads a start value. The block counts it down to zero on enabled cycles and signals expiry with a one-cycle `Zero` pulse. It sits beside the CPU as a timer peripheral, and `Zero` is intended as an interrupt request source.

## Interface
- `WIDTH`, default 64: counter width in bits.
- `PRESCALE`, default 4: enabled cycles per tick when `Slt`=1. Must be ≥2. The prescaler register width is clog2(PRESCALE).

Ports:
- `Clk` in 1: the single clock; all state updates on its rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Load` in 1: load `LoadValue` and start counting.
- `LoadValue` in WIDTH: start value, sampled when `Load`=1.
- `En` in 1: count enable; the block holds all state when it is 0.
- `Slt` in 1: 0 means one tick per enabled cycle; 1 means one tick per PRESCALE enabled cycles.
- `Reload` in 1: auto-reload request. Only effective with `COUNTDOWN_AUTORELOAD_EN`.
- `Count` out WIDTH: current count value.
- `Zero` out 1: one-cycle expiry pulse.
- `Busy` out 1: high while in state RUN.

## Operation
- Internal registers: `Count`, `Preset` (last loaded value), prescaler `ti`, and a 2-bit state in {IDLE, RUN, EXPIRED}.
- Reset, while `Reset_n`=0 (asynchronous):
  - `Count`=0, `Preset`=0, `ti`=0.
  - State IDLE, `Zero`=0, `Busy`=0.
- Load has the highest priority in every state.
  - `Load`=1 sets `Count`←`LoadValue`, `Preset`←`LoadValue`, `ti`←0.
  - Next state is RUN if `LoadValue`≠0, otherwise IDLE.
  - A load with value 0 produces no `Zero` pulse.
- Tick condition: state RUN, `En`=1, and either `Slt`=0, or `Slt`=1 with `ti`=PRESCALE−1.
- Prescaler: in RUN with `En`=1 and `Slt`=1, `ti` advances by 1 and wraps to 0 after PRESCALE−1. It holds otherwise, including across changes of `Slt`.
- On a tick with `Count`>1: `Count`←`Count`−1.
- On a terminal tick (`Count`=1, no reload):
  - `Count`←0 and state goes to EXPIRED.
  - EXPIRED lasts exactly one cycle with `Zero`=1, then the state goes to IDLE.
- IDLE: `Count` holds and `Zero`=0. Only `Load` leaves IDLE.
- `En`=0 in RUN freezes `Count` and `ti`. The state stays RUN and `Busy` stays 1.
- Arithmetic: `Count` is unsigned with no signed interpretation. Underflow cannot occur because 0 is never decremented.

## Timing
- `Load` sampled at edge N: `Count`=`LoadValue` and `Busy`=1 after edge N.
- With `Slt`=0 and `En` held at 1, loading value V gives `Count`=0 and `Zero`=1 V edges after the load edge. `Zero` falls on the next edge.
- With `Slt`=1, expiry takes V·PRESCALE enabled cycles after the load.
- `Zero` and `Busy` are registered and are never high in the same cycle (without reload).
- `Load` on the same edge as a terminal tick: the load wins and no `Zero` pulse occurs.
- `Load` during EXPIRED: the current `Zero` pulse completes, and the state enters RUN (or IDLE) on that same edge.
- `Reset_n` asserted mid-count: all outputs clear immediately, without waiting for a clock edge.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined, and a terminal tick occurs with `Reload`=1:
  - `Count`←`Preset` (0 is skipped) and the state stays RUN.
  - `Zero` is 1 for the following cycle while `Busy` stays 1.
  - `ti` continues its wrap without being cleared.
- `COUNTDOWN_AUTORELOAD_EN` undefined:
  - `Reload` is ignored and every terminal tick goes to EXPIRED.
  - `Preset` may be optimised away.

## Test plan
- Reset then idle: pulse `Reset_n` low mid-cycle → `Count`=0, `Zero`=0, `Busy`=0 with no clock edge needed; 10 cycles with `En`=1 and no `Load` → no change.
- Direct count: `Load` 5, `Slt`=0, `En`=1 → `Count` reads 4,3,2,1,0; `Zero`=1 exactly on the cycle `Count`=0; `Busy` drops on that same edge; IDLE afterwards.
- Prescaled count with gaps: `Load` 3, `Slt`=1, `En` toggling 1,0,1,0 → `Zero` after exactly 12 enabled cycles; `Count` frozen whenever `En`=0.
- Mid-run `Slt` switch: `Load` 10, 2 enabled cycles at `Slt`=1, then `Slt`=0 → `Count` decrements every cycle from 10; switching back to `Slt`=1 resumes with `ti`=2.
- Load collision: `Load` 7 on the cycle `Count` goes 1→0 → no `Zero`, `Count`=7, `Busy`=1; `Load` 0 → IDLE and no `Zero`.
- Auto-reload (`COUNTDOWN_AUTORELOAD_EN` defined): `Load` 2, `Reload`=1, `Slt`=0 → `Count` 1,2,1,2…; `Zero` pulses every 2 cycles; `Busy` stays 1. With the macro undefined → single expiry, then IDLE.

Source files
------------

// File: rtl/countdown_if.sv
// Bus bundle for the countdown timer: control inputs from the controller and
// the registered timer outputs back to it.
interface countdown_if #(
    parameter int WIDTH = 64
);
    // No handshake: Load qualifies LoadValue in the cycle it is high, En/Slt/Reload
    // are level controls sampled every rising edge, and Count/Zero/Busy are always valid.
    logic             Load;
    logic [WIDTH-1:0] LoadValue;
    logic             En;
    logic             Slt;
    logic             Reload;
    logic [WIDTH-1:0] Count;
    logic             Zero;
    logic             Busy;

    modport master (
        output Load, LoadValue, En, Slt, Reload,
        input  Count, Zero, Busy
    );

    modport slave (
        input  Load, LoadValue, En, Slt, Reload,
        output Count, Zero, Busy
    );
endinterface

// File: rtl/countdown.sv
// Loadable down-counting timer with optional divide-by-PRESCALE tick and a one-cycle Zero pulse.
// Define COUNTDOWN_AUTORELOAD_EN to reload Count from the last loaded value on a terminal tick.
module countdown #(
    parameter int WIDTH    = 64,
    parameter int PRESCALE = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    countdown_if.slave bus,
    output logic [1:0] State
);
    localparam int                TI_W   = $clog2(PRESCALE);
    localparam logic [TI_W-1:0]   TI_MAX = TI_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [TI_W-1:0]  ti_q, ti_d;
    logic             zero_q, zero_d;
    logic             tick;
    logic             terminal;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] preset_q, preset_d;
`else
    logic unused_reload;
    assign unused_reload = bus.Reload;
`endif

    assign tick     = (state_q == RUN) && bus.En && (!bus.Slt || (ti_q == TI_MAX));
    assign terminal = tick && (count_q == WIDTH'(1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            ti_q     <= '0;
            zero_q   <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            preset_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ti_q     <= ti_d;
            zero_q   <= zero_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
            preset_q <= preset_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ti_d     = ti_q;
        zero_d   = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        preset_d = preset_q;
`endif
        if (bus.Load) begin
            // A load beats any tick in flight, so a colliding terminal tick never pulses Zero.
            count_d  = bus.LoadValue;
            ti_d     = '0;
            state_d  = (bus.LoadValue != '0) ? RUN : IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
            preset_d = bus.LoadValue;
`endif
        end else begin
            if ((state_q == RUN) && bus.En && bus.Slt)
                ti_d = (ti_q == TI_MAX) ? '0 : ti_q + TI_W'(1);
            case (state_q)
                RUN: begin
                    if (terminal) begin
                        zero_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        if (bus.Reload) begin
                            count_d = preset_q;
                        end else begin
                            count_d = '0;
                            state_d = EXPIRED;
                        end
`else
                        count_d = '0;
                        state_d = EXPIRED;
`endif
                    end else if (tick) begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                EXPIRED: state_d = IDLE;
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.Count = count_q;
        bus.Zero  = zero_q;
        bus.Busy  = (state_q == RUN);
        State     = state_q;
    end
endmodule

// File: tb/tb_countdown.sv
// Directed bench for countdown: a driver pushes the expected post-edge outputs,
// a negedge monitor pops and compares them.
module tb_countdown;
  localparam int WIDTH    = 16;
  localparam int PRESCALE = 4;
  localparam int W        = WIDTH + 2;

  logic       Clk     = 1'b0;
  logic       Reset_n = 1'b1;
  logic [1:0] dbg_state;

  countdown_if #(.WIDTH(WIDTH)) bus ();

  countdown #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus),
    .State   (dbg_state)
  );

  // clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected end before 200000");
    $fatal(1);
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;

  task automatic report(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got count=%0d zero=%0b busy=%0b, expected count=%0d zero=%0b busy=%0b",
               tag, act[W-1:2], act[1], act[0], exp[W-1:2], exp[1], exp[0]);
    end
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      report(t, {bus.Count, bus.Zero, bus.Busy}, e);
    end
  end

  // driver
  task automatic step(input string tag, input logic load, input logic [WIDTH-1:0] lv,
                      input logic en, input logic slt, input logic reload,
                      input logic [WIDTH-1:0] e_cnt, input logic e_zero, input logic e_busy);
    bus.Load      = load;
    bus.LoadValue = lv;
    bus.En        = en;
    bus.Slt       = slt;
    bus.Reload    = reload;
    @(posedge Clk);
    exp_q.push_back({e_cnt, e_zero, e_busy});
    tag_q.push_back(tag);
    @(negedge Clk);
  endtask

  int k;

  initial begin
    bus.Load = 1'b0; bus.LoadValue = '0; bus.En = 1'b1; bus.Slt = 1'b0; bus.Reload = 1'b0;

    // asynchronous reset before any clock edge
    #1 Reset_n = 1'b0;
    #2 report("reset_async", {bus.Count, bus.Zero, bus.Busy}, {16'd0, 1'b0, 1'b0});
    @(negedge Clk) Reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      step("idle_noload", 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

    // direct count from 5
    step("direct_load", 1'b1, 16'd5, 1'b1, 1'b0, 1'b0, 16'd5, 1'b0, 1'b1);
    step("direct_4",    1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0, 1'b1);
    step("direct_3",    1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 1'b1);
    step("direct_2",    1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1);
    step("direct_1",    1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 1'b1);
    step("direct_zero", 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
    step("direct_idle", 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    step("direct_hold", 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

    // prescaled count from 3 with En toggling: one decrement per 4 enabled cycles
    step("pre_load", 1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 16'd3, 1'b0, 1'b1);
    k = 0;
    for (int i = 0; k < 12; i++) begin
      logic en_b;
      en_b = (i % 2 == 0);
      if (en_b) k++;
      step("pre_gap", 1'b0, 16'd0, en_b, 1'b1, 1'b0,
           WIDTH'(3 - k / 4), en_b && (k == 12), k < 12);
    end
    step("pre_after", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);

    // Slt switched mid-run: ti holds at 2 across the Slt=0 stretch
    step("slt_load",  1'b1, 16'd10, 1'b1, 1'b1, 1'b0, 16'd10, 1'b0, 1'b1);
    step("slt_pre1",  1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd10, 1'b0, 1'b1);
    step("slt_pre2",  1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd10, 1'b0, 1'b1);
    step("slt_dir9",  1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd9,  1'b0, 1'b1);
    step("slt_dir8",  1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd8,  1'b0, 1'b1);
    step("slt_dir7",  1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd7,  1'b0, 1'b1);
    step("slt_ti2",   1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd7,  1'b0, 1'b1);
    step("slt_ti3",   1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd6,  1'b0, 1'b1);
    step("slt_ti0",   1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd6,  1'b0, 1'b1);
    step("slt_ti1",   1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd6,  1'b0, 1'b1);
    step("slt_ti2b",  1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd6,  1'b0, 1'b1);
    step("slt_ti3b",  1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd5,  1'b0, 1'b1);

    // load collides with the terminal tick, then load of 0
    step("col_load2", 1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1);
    step("col_1",     1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 1'b1);
    step("col_load7", 1'b1, 16'd7, 1'b1, 1'b0, 1'b0, 16'd7, 1'b0, 1'b1);
    step("col_6",     1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd6, 1'b0, 1'b1);
    step("col_load0", 1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    step("col_idle",  1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

    // load during EXPIRED
    step("exp_load1", 1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 1'b1);
    step("exp_zero",  1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
    step("exp_load4", 1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0, 1'b1);
    step("exp_3",     1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 1'b1);

    // auto-reload request
    step("ar_load2",  1'b1, 16'd2, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 1'b1);
    step("ar_1a",     1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1);
`ifdef COUNTDOWN_AUTORELOAD_EN
    step("ar_2a",     1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b1, 1'b1);
    step("ar_1b",     1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1);
    step("ar_2b",     1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b1, 1'b1);
    step("ar_1c",     1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1);
`else
    step("ar_zero",   1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0);
    step("ar_idle",   1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0);
    step("ar_hold",   1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0);
`endif
    step("ar_stop",   1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a count
    step("rst_load9", 1'b1, 16'd9, 1'b1, 1'b0, 1'b0, 16'd9, 1'b0, 1'b1);
    step("rst_8",     1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd8, 1'b0, 1'b1);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 report("rst_mid_async", {bus.Count, bus.Zero, bus.Busy}, {16'd0, 1'b0, 1'b0});
    @(negedge Clk) Reset_n = 1'b1;
    step("rst_idle",  1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

    // drain the scoreboard
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
